// File: rtl/noc_skid_buffer_pkg.sv
// Shared link-stage constants: flit width and the occupancy encoding
// (EMPTY/BUSY/FULL) reused by other NoC link stages.
package noc_skid_buffer_pkg;

    localparam int FLIT_W = 64;

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_BUSY  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/noc_pipe_reg.sv
// DATA_W-wide enable-gated register with synchronous active-low clear.
module noc_pipe_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/noc_skid_buffer.sv
// Two-entry valid/ready skid buffer: registered in_ready, registered data path,
// full throughput, plus a saturating stall counter for link back-pressure debug.
module noc_skid_buffer
    import noc_skid_buffer_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    occ_e              state, state_nxt;
    logic              acc, pop;
    logic              main_en, skid_en, main_sel_skid;
    logic [DATA_W-1:0] main_d, skid_q;

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= OCC_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = 1'b0;
        case (state)
            OCC_EMPTY: begin
                if (acc) begin
                    main_en   = 1'b1;
                    state_nxt = OCC_BUSY;
                end
            end
            OCC_BUSY: begin
                if (acc && pop) begin
                    main_en = 1'b1;
                end else if (acc) begin
                    skid_en   = 1'b1;
                    state_nxt = OCC_FULL;
                end else if (pop) begin
                    state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_nxt     = OCC_BUSY;
                end
            end
            default: state_nxt = OCC_EMPTY;
        endcase
    end

    assign main_d = main_sel_skid ? skid_q : in_data;

    noc_pipe_reg #(.DATA_W(DATA_W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (out_data)
    );

    noc_pipe_reg #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    // Looks at next state only, so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) in_ready <= 1'b0;
        else        in_ready <= (state_nxt != OCC_FULL);
    end

    assign out_valid = (state != OCC_EMPTY);
    assign occupancy = state;

    always_ff @(posedge clk) begin
        if (!rst_n)                                              stall_cnt <= '0;
        else if (stall_cnt_clr)                                  stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_noc_skid_buffer.sv
// Directed bench for noc_skid_buffer (CNT_W = 3 so saturation is reachable).
module tb_noc_skid_buffer;

    localparam int DW = 64;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic          stall_cnt_clr;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    noc_skid_buffer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .occupancy     (occupancy),
        .stall_cnt     (stall_cnt),
        .stall_cnt_clr (stall_cnt_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall_cnt_clr = 1'b0;

        // reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_occ", occupancy, 0);
            chk("rst_stall", stall_cnt, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        // streaming 0x1..0x10 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            tick();
            chk("strm_in_ready", in_ready, 1);
            chk("strm_out_valid", out_valid, 1);
            chk("strm_out_data", out_data, 64'(i));
            chk("strm_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("strm_drain_occ", occupancy, 0);
        chk("strm_drain_vld", out_valid, 0);
        chk("strm_skid_unused", dut.u_skid.q, 0);

        // back-pressure: A, B fill both entries, C must wait
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hA;
        tick();
        chk("bp_a_occ", occupancy, 1);
        chk("bp_a_data", out_data, 64'hA);
        in_data = 64'hB;
        tick();
        chk("bp_full_occ", occupancy, 2);
        chk("bp_full_rdy", in_ready, 0);
        chk("bp_full_data", out_data, 64'hA);
        in_data = 64'hC;
        tick();
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_rdy", in_ready, 0);
        chk("bp_hold_data", out_data, 64'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_pop_a_data", out_data, 64'hB);
        chk("bp_pop_a_occ", occupancy, 1);
        chk("bp_pop_a_rdy", in_ready, 1);
        tick();
        chk("bp_c_data", out_data, 64'hC);
        chk("bp_c_occ", occupancy, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty_occ", occupancy, 0);

        // stall counter: count, clear mid-stall, saturate
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        chk("st_clr0", stall_cnt, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hD1;
        tick();
        in_valid = 1'b0;
        chk("st_first", stall_cnt, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("st_five", stall_cnt, 5);
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        chk("st_clr", stall_cnt, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("st_sat", stall_cnt, 7);
        chk("st_hold_data", out_data, 64'hD1);
        out_ready = 1'b1;
        tick();
        chk("st_drain_occ", occupancy, 0);
        chk("st_after_drain", stall_cnt, 7);

        // out_ready toggling while empty does nothing
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        chk("idle_occ", occupancy, 0);
        chk("idle_vld", out_valid, 0);
        chk("idle_stall", stall_cnt, 7);

        // mid-operation reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hE1;
        tick();
        in_data = 64'hE2;
        tick();
        chk("mr_full", occupancy, 2);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_occ", occupancy, 0);
        chk("mr_vld", out_valid, 0);
        chk("mr_rdy", in_ready, 0);
        chk("mr_data", out_data, 0);
        chk("mr_stall", stall_cnt, 0);
        out_ready = 1'b1;
        tick();
        chk("mr_rel_rdy", in_ready, 1);
        chk("mr_no_stale", out_valid, 0);
        in_valid = 1'b1; in_data = 64'hF1;
        tick();
        in_valid = 1'b0;
        chk("mr_new_data", out_data, 64'hF1);
        chk("mr_new_occ", occupancy, 1);
        tick();
        chk("mr_end_occ", occupancy, 0);
        chk("mr_end_vld", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
